// File: rtl/uart_frame_collector.sv
// Packs byte pairs from a UART receiver into 16-bit samples and holds a full
// frame until the consumer acks it. A partial frame is dropped on a line error or idle timeout.
//
// state   | meaning
// COLLECT | gathering byte pairs into buffer[wr_idx]
// FULL    | frame complete and held; bytes are dropped and flagged as overflow
module uart_frame_collector #(
    parameter int SAMPLE_NUM   = 16,
    parameter int TIMEOUT_CLKS = 52080
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_Received_byte,
    input  logic                          i_receive_state,
    input  logic                          i_error,
    input  logic [$clog2(SAMPLE_NUM)-1:0] i_rd_addr,
    input  logic                          i_frame_ack,
    output logic [15:0]                   o_rd_data,
    output logic                          o_frame_ready,
    output logic [$clog2(SAMPLE_NUM):0]   o_fill_count,
    output logic                          o_frame_error,
    output logic                          o_overflow
);

    localparam int AW = $clog2(SAMPLE_NUM);
    localparam int IW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(SAMPLE_NUM - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CLKS - 1);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_next;
    logic          phase, phase_next;
    logic [7:0]    low_byte, low_byte_next;
    logic [AW-1:0] wr_idx, wr_idx_next;
    logic [AW:0]   fill_count, fill_count_next;
    logic [IW-1:0] idle_cnt, idle_cnt_next, idle_inc;
    logic          overflow, overflow_next;
    logic          frame_error, frame_error_next;
    logic          buf_we;
    logic          partial;
    logic [15:0]   rd_data;
    logic [15:0]   buffer [SAMPLE_NUM];

    assign partial  = (wr_idx != '0) || phase;
    assign idle_inc = idle_cnt + IW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= COLLECT;
            phase       <= 1'b0;
            low_byte    <= 8'h00;
            wr_idx      <= '0;
            fill_count  <= '0;
            idle_cnt    <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            low_byte    <= low_byte_next;
            wr_idx      <= wr_idx_next;
            fill_count  <= fill_count_next;
            idle_cnt    <= idle_cnt_next;
            overflow    <= overflow_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        phase_next       = phase;
        low_byte_next    = low_byte;
        wr_idx_next      = wr_idx;
        fill_count_next  = fill_count;
        idle_cnt_next    = '0;
        overflow_next    = overflow;
        frame_error_next = 1'b0;
        buf_we           = 1'b0;

        if (state == COLLECT) begin
            if (i_error) begin
                wr_idx_next      = '0;
                phase_next       = 1'b0;
                fill_count_next  = '0;
                frame_error_next = 1'b1;
            end else if (i_receive_state) begin
                if (!phase) begin
                    low_byte_next = i_Received_byte;
                    phase_next    = 1'b1;
                end else begin
                    buf_we          = 1'b1;
                    wr_idx_next     = wr_idx + AW'(1);
                    fill_count_next = fill_count + (AW+1)'(1);
                    phase_next      = 1'b0;
                    if (wr_idx == LAST_IDX)
                        state_next = FULL;
                end
            end else if (partial) begin
                // Discard on the edge where the count would reach its terminal value.
                if (idle_inc == IDLE_LAST) begin
                    wr_idx_next      = '0;
                    phase_next       = 1'b0;
                    fill_count_next  = '0;
                    frame_error_next = 1'b1;
                end else begin
                    idle_cnt_next = idle_inc;
                end
            end
        end else begin
            if (i_frame_ack) begin
                state_next      = COLLECT;
                wr_idx_next     = '0;
                fill_count_next = '0;
                overflow_next   = 1'b0;
                phase_next      = i_receive_state;
                if (i_receive_state)
                    low_byte_next = i_Received_byte;
            end else if (i_receive_state) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we)
            buffer[wr_idx] <= {i_Received_byte, low_byte};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rd_data <= 16'h0000;
        else
            rd_data <= buffer[i_rd_addr];
    end

    assign o_rd_data     = rd_data;
    assign o_frame_ready = (state == FULL);
    assign o_fill_count  = fill_count;
    assign o_frame_error = frame_error;
    assign o_overflow    = overflow;

endmodule

// File: tb/tb_uart_frame_collector.sv
// Directed bench for uart_frame_collector: frame fill, overflow, error,
// timeout, coincident ack/byte and mid-frame reset, with hand-computed expectations.
module tb_uart_frame_collector;

    localparam int SN = 16;
    localparam int TO = 40;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_error;
    logic [3:0]  rd_addr;
    logic        frame_ack;
    logic [15:0] rd_data;
    logic        frame_ready;
    logic [4:0]  fill_count;
    logic        frame_error;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_frame_collector #(.SAMPLE_NUM(SN), .TIMEOUT_CLKS(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_Received_byte (rx_byte),
        .i_receive_state (rx_valid),
        .i_error         (rx_error),
        .i_rd_addr       (rd_addr),
        .i_frame_ack     (frame_ack),
        .o_rd_data       (rd_data),
        .o_frame_ready   (frame_ready),
        .o_fill_count    (fill_count),
        .o_frame_error   (frame_error),
        .o_overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the task returns at the falling edge
    // after the capturing rising edge, so registered effects are visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] first, input int count);
        for (int k = 0; k < count; k++)
            send_byte(first + 8'(k));
    endtask

    task automatic pulse_error();
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    int pulses;

    initial begin
        rst_n     = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rd_addr   = 4'd0;
        frame_ack = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready",    32'(frame_ready), 32'd0);
        check("rst_fill",     32'(fill_count),  32'd0);
        check("rst_ferr",     32'(frame_error), 32'd0);
        check("rst_ovf",      32'(overflow),    32'd0);
        check("rst_rd_data",  32'(rd_data),     32'd0);
        rst_n = 1'b1;

        // Full frame of bytes 0x00..0x1F
        send_range(8'h00, 31);
        check("fill_31_bytes",  32'(fill_count),  32'd15);
        check("ready_31_bytes", 32'(frame_ready), 32'd0);
        send_byte(8'h1F);
        check("fill_full",  32'(fill_count),  32'd16);
        check("ready_full", 32'(frame_ready), 32'd1);
        read_check("rd_a0",  4'd0,  16'h0100);
        read_check("rd_a5",  4'd5,  16'h0B0A);
        read_check("rd_a15", 4'd15, 16'h1F1E);

        // Byte while FULL is dropped
        send_byte(8'h55);
        check("ovf_set",       32'(overflow),    32'd1);
        check("ovf_ready",     32'(frame_ready), 32'd1);
        read_check("ovf_rd_a0",  4'd0,  16'h0100);
        read_check("ovf_rd_a15", 4'd15, 16'h1F1E);

        pulse_error();
        check("full_err_ignored", 32'(frame_error), 32'd0);
        check("full_err_fill",    32'(fill_count),  32'd16);

        pulse_ack();
        check("ack_ready", 32'(frame_ready), 32'd0);
        check("ack_ovf",   32'(overflow),    32'd0);
        check("ack_fill",  32'(fill_count),  32'd0);

        // Error on an empty frame still pulses
        pulse_error();
        check("empty_err_pulse", 32'(frame_error), 32'd1);
        @(negedge clk);
        check("empty_err_clear", 32'(frame_error), 32'd0);

        // Partial frame, ack in COLLECT ignored, then error
        send_range(8'h30, 4);
        pulse_ack();
        check("collect_ack_fill",  32'(fill_count),  32'd2);
        check("collect_ack_ready", 32'(frame_ready), 32'd0);
        send_byte(8'h34);
        pulse_error();
        check("err_pulse", 32'(frame_error), 32'd1);
        check("err_fill",  32'(fill_count),  32'd0);
        @(negedge clk);
        check("err_pulse_once", 32'(frame_error), 32'd0);

        // Clean frame 0x40..0x5F; sample 0 read during its own write returns old data
        rd_addr = 4'd0;
        send_byte(8'h40);
        send_byte(8'h41);
        check("rd_same_cycle_old", 32'(rd_data), 32'h3130);
        send_range(8'h42, 30);
        check("err_frame_fill",  32'(fill_count),  32'd16);
        check("err_frame_ready", 32'(frame_ready), 32'd1);
        read_check("err_frame_a0",  4'd0,  16'h4140);
        read_check("err_frame_a15", 4'd15, 16'h5F5E);
        pulse_ack();

        // Timeout on a 3-byte partial frame
        send_range(8'h60, 3);
        repeat (TO - 2) @(negedge clk);
        check("to_before",      32'(frame_error), 32'd0);
        check("to_before_fill", 32'(fill_count),  32'd1);
        @(negedge clk);
        check("to_pulse",      32'(frame_error), 32'd1);
        check("to_pulse_fill", 32'(fill_count),  32'd0);
        @(negedge clk);
        check("to_pulse_once", 32'(frame_error), 32'd0);

        pulses = 0;
        for (int k = 0; k < 2 * TO; k++) begin
            @(negedge clk);
            if (frame_error) pulses++;
        end
        check("idle_empty_no_pulse", 32'(pulses), 32'd0);

        // Ack coincident with a byte while FULL
        send_range(8'h00, 32);
        send_byte(8'h77);
        check("sim_ovf_pre", 32'(overflow), 32'd1);
        @(negedge clk);
        frame_ack = 1'b1;
        rx_byte   = 8'hAA;
        rx_valid  = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        rx_valid  = 1'b0;
        check("sim_ready", 32'(frame_ready), 32'd0);
        check("sim_ovf",   32'(overflow),    32'd0);
        check("sim_fill",  32'(fill_count),  32'd0);
        send_byte(8'hBB);
        check("sim_fill_1", 32'(fill_count), 32'd1);
        read_check("sim_rd_a0", 4'd0, 16'hBBAA);

        // Reset mid-frame
        pulse_error();
        send_range(8'hC0, 9);
        check("pre_rst_fill", 32'(fill_count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(frame_ready), 32'd0);
        check("arst_fill",  32'(fill_count),  32'd0);
        check("arst_ferr",  32'(frame_error), 32'd0);
        check("arst_ovf",   32'(overflow),    32'd0);
        check("arst_rd",    32'(rd_data),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_range(8'h80, 32);
        check("post_rst_fill",  32'(fill_count),  32'd16);
        check("post_rst_ready", 32'(frame_ready), 32'd1);
        read_check("post_rst_a0",  4'd0,  16'h8180);
        read_check("post_rst_a7",  4'd7,  16'h8F8E);
        read_check("post_rst_a15", 4'd15, 16'h9F9E);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
